// File: rtl/ccip_if_pkg.sv
// rtl/ccip_if_pkg.sv - CCI-P c1 channel request/response pass-through types
package ccip_if_pkg;

    typedef enum logic [3:0] {
        eREQ_WRLINE_I = 4'h0,
        eREQ_WRLINE_M = 4'h1,
        eREQ_WRPUSH_I = 4'h2,
        eREQ_WRFENCE  = 4'h4
    } t_ccip_c1_req;

    typedef enum logic [3:0] {
        eRSP_WRLINE  = 4'h0,
        eRSP_WRFENCE = 4'h4
    } t_ccip_c1_rsp;

    // Encoded line count minus one: 0 -> 1 line, 1 -> 2 lines, 3 -> 4 lines
    typedef logic [1:0] t_ccip_clLen;

    localparam t_ccip_clLen eCL_LEN_1 = 2'b00;
    localparam t_ccip_clLen eCL_LEN_2 = 2'b01;
    localparam t_ccip_clLen eCL_LEN_4 = 2'b11;

    typedef logic [511:0] t_ccip_clData;

    typedef struct packed {
        logic [1:0]   vc_sel;
        logic         sop;
        t_ccip_clLen  cl_len;
        t_ccip_c1_req req_type;
        logic [41:0]  address;
        logic [15:0]  mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        t_ccip_clData       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        logic [1:0]   vc_used;
        logic         hit_miss;
        logic         format;
        logic [1:0]   cl_num;
        t_ccip_c1_rsp resp_type;
        logic [15:0]  mdata;
    } t_ccip_c1_RspMemHdr;

    typedef struct packed {
        t_ccip_c1_RspMemHdr hdr;
        logic               rspValid;
    } t_if_ccip_c1_Rx;

endpackage

// File: rtl/dma_wr_buf_pkg.sv
// rtl/dma_wr_buf_pkg.sv - defaults, outstanding/cost types and line-cost helpers
package dma_wr_buf_pkg;
    import ccip_if_pkg::*;

    localparam int DEF_FIFO_DEPTH      = 16;
    localparam int DEF_ALMFULL_THRESH  = 12;
    localparam int DEF_MAX_OUTSTANDING = 256;

    typedef logic [8:0] t_outstanding;

    // Line cost of one entry; largest value is 4 (a 4-line sop)
    typedef logic [2:0] t_cost;

    localparam t_cost COST_NONE = 3'd0;
    localparam t_cost COST_ONE  = 3'd1;

    // Lines a request adds to the in-flight count; only a write sop carries cost
    function automatic t_cost req_cost(input t_ccip_c1_req req_type,
                                       input logic         sop,
                                       input t_ccip_clLen  cl_len);
        t_cost c;
        c = COST_NONE;
        if (req_type != eREQ_WRFENCE && sop)
            c = {1'b0, cl_len} + COST_ONE;
        return c;
    endfunction

    // Lines a response retires; a packed response covers cl_num+1 lines
    function automatic t_cost rsp_credit(input t_ccip_c1_rsp resp_type,
                                         input logic         format,
                                         input logic [1:0]   cl_num);
        t_cost c;
        c = COST_NONE;
        if (resp_type == eRSP_WRLINE)
            c = format ? ({1'b0, cl_num} + COST_ONE) : COST_ONE;
        return c;
    endfunction

endpackage

// File: rtl/dma_wr_buf_fifo.sv
// rtl/dma_wr_buf_fifo.sv - synchronous request FIFO with count/full/empty
module dma_wr_buf_fifo
    import ccip_if_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           push,
    input  t_if_ccip_c1_Tx push_data,
    input  logic           pop,
    output t_if_ccip_c1_Tx head,
    output logic [AW:0]    count,
    output logic           full,
    output logic           empty
);

    t_if_ccip_c1_Tx mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage array; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dma_wr_req_buf.sv
// rtl/dma_wr_req_buf.sv - c1 write request buffer with line budget; stats under DMA_WR_STATS_EN
module dma_wr_req_buf
    import ccip_if_pkg::*;
    import dma_wr_buf_pkg::*;
#(
    parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
    parameter int ALMFULL_THRESH  = DEF_ALMFULL_THRESH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic           Clk_400,
    input  logic           SoftReset_n,
    input  t_if_ccip_c1_Tx afu_c1Tx,
    output logic           afu_c1TxAlmFull,
    output t_if_ccip_c1_Tx mpf_c1Tx,
    input  logic           mpf_c1TxAlmFull,
    input  t_if_ccip_c1_Rx mpf_c1Rx,
    output t_outstanding   outstanding,
    output logic           idle,
    output logic           ovf_err,
    output logic [31:0]    stat_lines,
    output logic [31:0]    stat_stall
);

    localparam int              CW       = $clog2(FIFO_DEPTH) + 1;
    localparam int              NW       = CW + 1;
    localparam logic [NW-1:0]   THRESH_V = NW'(ALMFULL_THRESH);
    localparam logic [9:0]      LIMIT_V  = 10'(MAX_OUTSTANDING);

    t_if_ccip_c1_Tx head;
    logic [CW-1:0]  fifo_count;
    logic           fifo_full;
    logic           fifo_empty;
    logic           push;
    logic           issue;
    t_cost          head_cost;
    t_cost          rsp_cost;
    logic [9:0]     budget_sum;
    logic [9:0]     out_up;
    logic [9:0]     out_dn;
    logic           underflow;
    logic [NW-1:0]  count_next;
    logic           unused_sink;

    dma_wr_buf_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (Clk_400),
        .resetn    (SoftReset_n),
        .push      (push),
        .push_data (afu_c1Tx),
        .pop       (issue),
        .head      (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign push      = afu_c1Tx.valid && !fifo_full;
    assign head_cost = req_cost(head.hdr.req_type, head.hdr.sop, head.hdr.cl_len);
    assign rsp_cost  = rsp_credit(mpf_c1Rx.hdr.resp_type, mpf_c1Rx.hdr.format,
                                  mpf_c1Rx.hdr.cl_num);

    // Non-sop beats and fences cost 0, so once a sop goes out its beats see only MPF backpressure
    assign budget_sum = {1'b0, outstanding} + 10'(head_cost);
    assign issue      = !fifo_empty && !mpf_c1TxAlmFull && (budget_sum <= LIMIT_V);

    // Issue and response land in a single net update of the in-flight count
    assign out_up     = issue ? budget_sum : {1'b0, outstanding};
    assign out_dn     = mpf_c1Rx.rspValid ? 10'(rsp_cost) : 10'd0;
    assign underflow  = (out_dn > out_up);

    assign count_next = NW'(fifo_count) + NW'(push) - NW'(issue);
    assign idle       = fifo_empty && (outstanding == '0);

    assign unused_sink = &{1'b0, head.valid, mpf_c1Rx.hdr.vc_used,
                           mpf_c1Rx.hdr.hit_miss, mpf_c1Rx.hdr.mdata};

    // Registered request toward MPF: valid pulses for exactly the issue cycle
    always_ff @(posedge Clk_400) begin
        if (!SoftReset_n) begin
            mpf_c1Tx <= '0;
        end else begin
            mpf_c1Tx.valid <= issue;
            if (issue) begin
                mpf_c1Tx.hdr  <= head.hdr;
                mpf_c1Tx.data <= head.data;
            end
        end
    end

    // Backpressure, in-flight line count and the sticky error flag
    always_ff @(posedge Clk_400) begin
        if (!SoftReset_n) begin
            afu_c1TxAlmFull <= 1'b0;
            outstanding     <= '0;
            ovf_err         <= 1'b0;
        end else begin
            afu_c1TxAlmFull <= (count_next >= THRESH_V);
            outstanding     <= underflow ? '0 : t_outstanding'(out_up - out_dn);
            if (underflow || (afu_c1Tx.valid && fifo_full))
                ovf_err <= 1'b1;
        end
    end

`ifdef DMA_WR_STATS_EN
    logic [31:0] lines_q;
    logic [31:0] stall_q;

    // Issued-line and stall-cycle counters, free-running with natural wrap
    always_ff @(posedge Clk_400) begin
        if (!SoftReset_n) begin
            lines_q <= '0;
            stall_q <= '0;
        end else begin
            if (issue)
                lines_q <= lines_q + 32'(head_cost);
            else if (!fifo_empty)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_lines = lines_q;
    assign stat_stall = stall_q;
`else
    assign stat_lines = '0;
    assign stat_stall = '0;
`endif

endmodule

// File: tb/tb_dma_wr_req_buf.sv
// tb/tb_dma_wr_req_buf.sv - randomized bench with queue-based reference model
module tb_dma_wr_req_buf;
    import ccip_if_pkg::*;
    import dma_wr_buf_pkg::*;

    localparam int DEPTH  = 16;
    localparam int THRESH = 12;
    localparam int MAXO   = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           resetn;
    t_if_ccip_c1_Tx afu_tx, mpf_tx;
    t_if_ccip_c1_Rx rx;
    logic           afu_af, mpf_af, idle, ovf;
    logic [8:0]     outst;
    logic [31:0]    st_lines, st_stall;

    t_if_ccip_c1_Tx b_afu_tx, b_mpf_tx;
    t_if_ccip_c1_Rx b_rx;
    logic           b_afu_af, b_mpf_af, b_idle, b_ovf;
    logic [8:0]     b_outst;
    logic [31:0]    b_sl, b_ss;

    dma_wr_req_buf dut (
        .Clk_400(clk), .SoftReset_n(resetn), .afu_c1Tx(afu_tx), .afu_c1TxAlmFull(afu_af),
        .mpf_c1Tx(mpf_tx), .mpf_c1TxAlmFull(mpf_af), .mpf_c1Rx(rx), .outstanding(outst),
        .idle(idle), .ovf_err(ovf), .stat_lines(st_lines), .stat_stall(st_stall)
    );

    dma_wr_req_buf #(.MAX_OUTSTANDING(4)) dut_b (
        .Clk_400(clk), .SoftReset_n(resetn), .afu_c1Tx(b_afu_tx), .afu_c1TxAlmFull(b_afu_af),
        .mpf_c1Tx(b_mpf_tx), .mpf_c1TxAlmFull(b_mpf_af), .mpf_c1Rx(b_rx), .outstanding(b_outst),
        .idle(b_idle), .ovf_err(b_ovf), .stat_lines(b_sl), .stat_stall(b_ss)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: buffered requests in a queue, in-flight lines as an integer
    t_if_ccip_c1_Tx mq[$];
    t_if_ccip_c1_Tx m_tx;
    int             m_out;
    bit             m_valid, m_ovf, m_af;
    logic [31:0]    m_lines, m_stall;
    int             main_issues, b_issues;

    function automatic int lines_of(t_if_ccip_c1_Tx t);
        if (t.hdr.req_type == eREQ_WRFENCE || !t.hdr.sop) return 0;
        return int'(t.hdr.cl_len) + 1;
    endfunction

    task automatic model_step();
        int  c, dec;
        bit  was_full;
        if (!resetn) begin
            mq.delete();
            m_out = 0; m_ovf = 0; m_af = 0; m_valid = 0; m_lines = 0; m_stall = 0;
            return;
        end
        was_full = (mq.size() == DEPTH);
        c = (mq.size() > 0) ? lines_of(mq[0]) : 0;
        m_valid = (mq.size() > 0) && !mpf_af && (m_out + c <= MAXO);
`ifdef DMA_WR_STATS_EN
        if (m_valid) m_lines += 32'(c);
        else if (mq.size() > 0) m_stall += 32'd1;
`endif
        if (m_valid) begin
            m_tx  = mq.pop_front();
            m_out = m_out + c;
        end
        dec = 0;
        if (rx.rspValid && rx.hdr.resp_type == eRSP_WRLINE)
            dec = rx.hdr.format ? int'(rx.hdr.cl_num) + 1 : 1;
        m_out = m_out - dec;
        if (m_out < 0) begin m_out = 0; m_ovf = 1; end
        if (afu_tx.valid) begin
            if (was_full) m_ovf = 1;
            else mq.push_back(afu_tx);
        end
        m_af = (mq.size() >= THRESH);
    endtask

    task automatic compare();
        check("mpf_valid", mpf_tx.valid, m_valid);
        if (m_valid) begin
            check("mpf_hdr", mpf_tx.hdr, m_tx.hdr);
            check("mpf_data", mpf_tx.data, m_tx.data);
        end
        check("afu_almfull", afu_af, m_af);
        check("outstanding", outst, m_out);
        check("idle", idle, (mq.size() == 0) && (m_out == 0));
        check("ovf_err", ovf, m_ovf);
        check("stat_lines", st_lines, m_lines);
        check("stat_stall", st_stall, m_stall);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare();
        if (mpf_tx.valid) main_issues++;
        if (b_mpf_tx.valid) b_issues++;
    endtask

    function automatic t_if_ccip_c1_Tx mk_req(t_ccip_c1_req ty, logic sop, t_ccip_clLen len);
        t_if_ccip_c1_Tx t;
        t = '0;
        t.valid        = 1'b1;
        t.hdr.req_type = ty;
        t.hdr.sop      = sop;
        t.hdr.cl_len   = len;
        t.hdr.vc_sel   = 2'($urandom);
        t.hdr.address  = {10'($urandom), $urandom};
        t.hdr.mdata    = 16'($urandom);
        for (int i = 0; i < 16; i++) t.data[i*32 +: 32] = $urandom;
        return t;
    endfunction

    function automatic t_if_ccip_c1_Rx mk_rsp(t_ccip_c1_rsp ty, logic fmt, logic [1:0] num);
        t_if_ccip_c1_Rx r;
        r = '0;
        r.rspValid      = 1'b1;
        r.hdr.resp_type = ty;
        r.hdr.format    = fmt;
        r.hdr.cl_num    = num;
        r.hdr.mdata     = 16'($urandom);
        return r;
    endfunction

    function automatic t_if_ccip_c1_Tx rand_req();
        t_ccip_c1_req ty;
        t_ccip_clLen  len;
        case ($urandom_range(0, 3))
            0:       ty = eREQ_WRLINE_I;
            1:       ty = eREQ_WRLINE_M;
            2:       ty = eREQ_WRPUSH_I;
            default: ty = eREQ_WRFENCE;
        endcase
        case ($urandom_range(0, 2))
            0:       len = eCL_LEN_1;
            1:       len = eCL_LEN_2;
            default: len = eCL_LEN_4;
        endcase
        return mk_req(ty, ($urandom_range(0, 3) != 0), len);
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        afu_tx = '0; rx = '0; b_afu_tx = '0; b_rx = '0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    initial begin
        mpf_af = 1'b0; b_mpf_af = 1'b0;
        main_issues = 0; b_issues = 0;
        do_reset();
        check("rst_valid", mpf_tx.valid, 1'b0);
        check("rst_outstanding", outst, 9'd0);
        check("rst_idle", idle, 1'b1);
        check("rst_almfull", afu_af, 1'b0);

        // Test 1: single line, 2-cycle latency, response retires it
        afu_tx = mk_req(eREQ_WRLINE_I, 1'b1, eCL_LEN_1);
        tick();
        afu_tx = '0;
        check("t1_cycle1_valid", mpf_tx.valid, 1'b0);
        tick();
        check("t1_cycle2_valid", mpf_tx.valid, 1'b1);
        check("t1_outstanding", outst, 9'd1);
        rx = mk_rsp(eRSP_WRLINE, 1'b0, 2'd0);
        tick();
        rx = '0;
        check("t1_out_after_rsp", outst, 9'd0);
        check("t1_idle", idle, 1'b1);

        // Test 2: fill with MPF stalled, almfull after 12th push, 17th dropped
        mpf_af = 1'b1;
        main_issues = 0;
        for (int i = 0; i < 16; i++) begin
            afu_tx = mk_req(eREQ_WRLINE_I, 1'b1, eCL_LEN_1);
            tick();
            if (i == 10) check("t2_almfull_after_11", afu_af, 1'b0);
            if (i == 11) check("t2_almfull_after_12", afu_af, 1'b1);
        end
        check("t2_ovf_at_16", ovf, 1'b0);
        afu_tx = mk_req(eREQ_WRLINE_I, 1'b1, eCL_LEN_1);
        tick();
        afu_tx = '0;
        check("t2_ovf_at_17", ovf, 1'b1);
        mpf_af = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        check("t2_issued", main_issues, 16);
        check("t2_outstanding", outst, 9'd16);
        rx = mk_rsp(eRSP_WRLINE, 1'b1, 2'd3);
        for (int i = 0; i < 4; i++) tick();
        rx = '0;
        check("t2_drained", outst, 9'd0);

        // Test 3: MAX_OUTSTANDING=4 instance, 4-line burst then 1-line held by budget
        b_issues = 0;
        b_afu_tx = mk_req(eREQ_WRLINE_I, 1'b1, eCL_LEN_4);
        tick();
        for (int i = 0; i < 3; i++) begin
            b_afu_tx = mk_req(eREQ_WRLINE_I, 1'b0, eCL_LEN_4);
            tick();
        end
        b_afu_tx = mk_req(eREQ_WRLINE_M, 1'b1, eCL_LEN_1);
        tick();
        b_afu_tx = '0;
        for (int i = 0; i < 6; i++) tick();
        check("t3_burst_issued", b_issues, 4);
        check("t3_out_full", b_outst, 9'd4);
        check("t3_held", b_mpf_tx.valid, 1'b0);
        b_rx = mk_rsp(eRSP_WRLINE, 1'b1, 2'd3);
        tick();
        b_rx = '0;
        check("t3_out_after_rsp", b_outst, 9'd0);
        check("t3_not_yet", b_mpf_tx.valid, 1'b0);
        tick();
        check("t3_released", b_mpf_tx.valid, 1'b1);
        check("t3_out_one", b_outst, 9'd1);
        check("t3_released_type", b_mpf_tx.hdr.req_type, eREQ_WRLINE_M);
        b_rx = mk_rsp(eRSP_WRLINE, 1'b0, 2'd0);
        tick();
        b_rx = '0;

        // Test 4: issue and response in the same cycle at outstanding=5
        for (int i = 0; i < 5; i++) begin
            afu_tx = mk_req(eREQ_WRLINE_I, 1'b1, eCL_LEN_1);
            tick();
        end
        afu_tx = '0;
        tick(); tick();
        check("t4_out5", outst, 9'd5);
        afu_tx = mk_req(eREQ_WRPUSH_I, 1'b1, eCL_LEN_1);
        tick();
        afu_tx = '0;
        rx = mk_rsp(eRSP_WRLINE, 1'b0, 2'd0);
        tick();
        rx = '0;
        check("t4_issue", mpf_tx.valid, 1'b1);
        check("t4_net_zero", outst, 9'd5);
        rx = mk_rsp(eRSP_WRLINE, 1'b1, 2'd3);
        tick();
        rx = mk_rsp(eRSP_WRLINE, 1'b0, 2'd0);
        tick();
        rx = '0;

        // Test 5: fence between two writes
        afu_tx = mk_req(eREQ_WRLINE_I, 1'b1, eCL_LEN_1);
        tick();
        afu_tx = mk_req(eREQ_WRFENCE, 1'b1, eCL_LEN_4);
        tick();
        afu_tx = mk_req(eREQ_WRLINE_M, 1'b1, eCL_LEN_1);
        tick();
        afu_tx = '0;
        check("t5_fence_issued", mpf_tx.hdr.req_type, eREQ_WRFENCE);
        tick(); tick();
        check("t5_out", outst, 9'd2);
        rx = mk_rsp(eRSP_WRFENCE, 1'b1, 2'd3);
        tick();
        rx = '0;
        check("t5_fence_rsp", outst, 9'd2);
        rx = mk_rsp(eRSP_WRLINE, 1'b1, 2'd1);
        tick();
        rx = '0;

        // Test 6: reset in the middle of a 4-beat burst
        afu_tx = mk_req(eREQ_WRLINE_I, 1'b1, eCL_LEN_4);
        tick();
        for (int i = 0; i < 2; i++) begin
            afu_tx = mk_req(eREQ_WRLINE_I, 1'b0, eCL_LEN_4);
            tick();
        end
        afu_tx = mk_req(eREQ_WRLINE_I, 1'b0, eCL_LEN_4);
        resetn = 1'b0;
        tick();
        afu_tx = '0;
        resetn = 1'b1;
        check("t6_valid", mpf_tx.valid, 1'b0);
        check("t6_out", outst, 9'd0);
        check("t6_stat_lines", st_lines, 32'd0);
        check("t6_stat_stall", st_stall, 32'd0);
        tick();
        check("t6_first_after", mpf_tx.valid, 1'b0);
        tick();
        check("t6_discarded", mpf_tx.valid, 1'b0);

        // Randomized phases with varying response pressure
        for (int ph = 0; ph < 8; ph++) begin
            int rsp_pct;
            do_reset();
            rsp_pct = 20 + ph * 10;
            for (int cyc = 0; cyc < 250; cyc++) begin
                afu_tx = ($urandom_range(0, 1) != 0) ? rand_req() : '0;
                mpf_af = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 99) < rsp_pct)
                    rx = mk_rsp(($urandom_range(0, 3) != 0) ? eRSP_WRLINE : eRSP_WRFENCE,
                                1'($urandom), 2'($urandom));
                else
                    rx = '0;
                tick();
            end
            afu_tx = '0; rx = '0; mpf_af = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
